// File: rtl/alu_issue_unit.sv
// alu_issue_unit: sequential front-end for an external combinational ALU.
// Accepts requests on a valid/ready channel and drives registered operands
// and opcode into the ALU. It captures the ALU result one cycle later and
// returns it on a valid/ready response channel.
//
// Optional feature (macro ALU_ISSUE_CHECK_EN): an internal reference model
// checks every captured result and raises a sticky chk_fail on mismatch.
// With the macro undefined, chk_fail is tied to 0.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   req_valid/req_ready          request handshake (req_ready is combinational)
//   req_op, req_a, req_b         opcode (000 add .. 100 slt, 101-111 illegal), operands
//   alu_a, alu_b, alu_op         registered drive into the external ALU
//   alu_result, alu_zero         ALU outputs, sampled at the end of EXEC
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_zero, rsp_err captured response payload
//   ops_done                     saturating count of response handshakes
//   chk_fail                     sticky self-check mismatch
`timescale 1ns/1ps

module alu_issue_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] ops_done,
  output logic             chk_fail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0]       OP_ADD  = 3'b000;
  localparam logic [2:0]       OP_SUB  = 3'b001;
  localparam logic [2:0]       OP_AND  = 3'b010;
  localparam logic [2:0]       OP_OR   = 3'b011;
  localparam logic [2:0]       OP_SLT  = 3'b100;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_op;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_ops_done;

  logic w_req_ready;
  logic w_accept;
  logic w_rsp_hs;
  logic w_legal;

  // Handshake qualifiers; a response handshake frees the slot in the same cycle.
  always_comb begin
    w_rsp_hs    = (r_state == RESP) & rsp_ready;
    w_req_ready = (r_state == IDLE) | w_rsp_hs;
    w_accept    = req_valid & w_req_ready;
    w_legal     = (req_op == OP_ADD) | (req_op == OP_SUB) | (req_op == OP_AND) |
                  (req_op == OP_OR)  | (req_op == OP_SLT);
  end

  // Control FSM with the registered datapath it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= OP_ADD;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_ops_done   <= '0;
    end else begin
      if (w_rsp_hs && (r_ops_done != CNT_MAX)) begin
        r_ops_done <= r_ops_done + CNT_W'(1);
      end
      case (r_state)
        IDLE, RESP: begin
          if (w_accept) begin
            if (w_legal) begin
              r_alu_a  <= req_a;
              r_alu_b  <= req_b;
              r_alu_op <= req_op;
              r_state  <= EXEC;
            end else begin
              // Illegal opcode: answer directly, ALU drive left untouched.
              r_rsp_result <= '0;
              r_rsp_zero   <= 1'b1;
              r_rsp_err    <= 1'b1;
              r_state      <= RESP;
            end
          end else if (w_rsp_hs) begin
            r_state <= IDLE;
          end
        end
        EXEC: begin
          r_rsp_result <= alu_result;
          r_rsp_zero   <= alu_zero;
          r_rsp_err    <= 1'b0;
          r_state      <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_CHECK_EN
  logic [WIDTH-1:0] w_exp_result;
  logic             r_chk_fail;

  // Reference result for the operands currently driven into the ALU.
  always_comb begin
    w_exp_result = '0;
    case (r_alu_op)
      OP_ADD:  w_exp_result = r_alu_a + r_alu_b;
      OP_SUB:  w_exp_result = r_alu_a - r_alu_b;
      OP_AND:  w_exp_result = r_alu_a & r_alu_b;
      OP_OR:   w_exp_result = r_alu_a | r_alu_b;
      OP_SLT:  w_exp_result = WIDTH'($signed(r_alu_a) < $signed(r_alu_b));
      default: w_exp_result = '0;
    endcase
  end

  // Sticky mismatch flag, evaluated on the EXEC capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_fail <= 1'b0;
    end else if ((r_state == EXEC) &&
                 ((alu_result != w_exp_result) || (alu_zero != (w_exp_result == '0)))) begin
      r_chk_fail <= 1'b1;
    end
  end

  assign chk_fail = r_chk_fail;
`else
  assign chk_fail = 1'b0;
`endif

  assign req_ready  = w_req_ready;
  assign rsp_valid  = (r_state == RESP);
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;
  assign ops_done   = r_ops_done;

endmodule
